// File: rtl/alu_result_collector_pkg.sv
// alu_result_collector_pkg: op encodings, FSM states and default widths shared by the collector files
package alu_result_collector_pkg;
  localparam int DATA_W_DEF = 4;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_NOT, OP_AND, OP_OR, OP_XOR, OP_LT, OP_EQ} op_e;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_e;
endpackage

// File: rtl/alu_result_collector_if.sv
// alu_result_collector_if: request, ALU and result handshake signals; master is the collector side
import alu_result_collector_pkg::*;
interface alu_result_collector_if #(parameter int DATA_W = DATA_W_DEF, parameter int CNT_W = CNT_W_DEF);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [2:0] in_op;
  logic in_acc;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0] alu_op;
  logic [DATA_W-1:0] alu_add;
  logic [DATA_W-1:0] alu_sub;
  logic [DATA_W-1:0] alu_not;
  logic [DATA_W-1:0] alu_and;
  logic [DATA_W-1:0] alu_or;
  logic [DATA_W-1:0] alu_xor;
  logic alu_lt;
  logic alu_eq;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] out_result;
  logic [2:0] out_op;
  logic out_zero;
  logic out_neg;
  logic [CNT_W-1:0] ops_done;
  modport master (
    input in_valid, in_a, in_b, in_op, in_acc,
    input alu_add, alu_sub, alu_not, alu_and, alu_or, alu_xor, alu_lt, alu_eq,
    input out_ready,
    output in_ready, alu_a, alu_b, alu_op,
    output out_valid, out_result, out_op, out_zero, out_neg, ops_done
  );
  modport slave (
    output in_valid, in_a, in_b, in_op, in_acc,
    output alu_add, alu_sub, alu_not, alu_and, alu_or, alu_xor, alu_lt, alu_eq,
    output out_ready,
    input in_ready, alu_a, alu_b, alu_op,
    input out_valid, out_result, out_op, out_zero, out_neg, ops_done
  );
endinterface

// File: rtl/alu_result_collector_sel.sv
// alu_result_collector_sel: picks the ALU output bus matching op; compares come back zero-extended
module alu_result_collector_sel
  import alu_result_collector_pkg::*;
#(parameter int DATA_W = DATA_W_DEF) (
  input logic [2:0] op,
  input logic [DATA_W-1:0] add_r,
  input logic [DATA_W-1:0] sub_r,
  input logic [DATA_W-1:0] not_r,
  input logic [DATA_W-1:0] and_r,
  input logic [DATA_W-1:0] or_r,
  input logic [DATA_W-1:0] xor_r,
  input logic lt,
  input logic eq,
  output logic [DATA_W-1:0] result
);
  // 8:1 selection over the fully decoded op field
  always_comb begin
    result = '0;
    case (op_e'(op))
      OP_ADD: result = add_r;
      OP_SUB: result = sub_r;
      OP_NOT: result = not_r;
      OP_AND: result = and_r;
      OP_OR: result = or_r;
      OP_XOR: result = xor_r;
      OP_LT: result = {{(DATA_W-1){1'b0}}, lt};
      OP_EQ: result = {{(DATA_W-1){1'b0}}, eq};
      default: result = '0;
    endcase
  end
endmodule

// File: rtl/alu_result_collector.sv
// alu_result_collector: registers ops into the ALU, captures the selected result and hands it off; ALU_COLLECTOR_ACC_MODE_EN enables chaining via in_acc
module alu_result_collector
  import alu_result_collector_pkg::*;
#(parameter int DATA_W = DATA_W_DEF, parameter int CNT_W = CNT_W_DEF) (
  input logic clk,
  input logic rst,
  alu_result_collector_if.master bus
);
  state_e state, state_nx;
  logic accept, handoff;
  logic [DATA_W-1:0] sel, a_nx;
  assign accept = bus.in_valid & bus.in_ready;
  assign handoff = bus.out_valid & bus.out_ready;
`ifdef ALU_COLLECTOR_ACC_MODE_EN
  logic [DATA_W-1:0] last;
  assign a_nx = bus.in_acc ? last : bus.in_a;
  // last handed-off result feeds chained operations
  always_ff @(posedge clk)
    if (rst) last <= '0;
    else if (handoff) last <= bus.out_result;
`else
  assign a_nx = bus.in_a;
`endif
  alu_result_collector_sel #(.DATA_W(DATA_W)) u_sel (
    .op(bus.alu_op),
    .add_r(bus.alu_add),
    .sub_r(bus.alu_sub),
    .not_r(bus.alu_not),
    .and_r(bus.alu_and),
    .or_r(bus.alu_or),
    .xor_r(bus.alu_xor),
    .lt(bus.alu_lt),
    .eq(bus.alu_eq),
    .result(sel)
  );
  // state register
  always_ff @(posedge clk)
    if (rst) state <= S_IDLE;
    else state <= state_nx;
  // next state and request-side ready; EXEC is the single ALU settle cycle
  always_comb begin
    bus.in_ready = (state == S_IDLE) | (state == S_DONE & bus.out_ready);
    state_nx = state == S_IDLE ? (accept ? S_EXEC : S_IDLE) :
               state == S_EXEC ? S_DONE :
               state == S_DONE ? (bus.out_ready ? (bus.in_valid ? S_EXEC : S_IDLE) : S_DONE) :
               S_IDLE;
  end
  // operand capture, result capture and handoff counting
  always_ff @(posedge clk)
    if (rst) begin
      bus.alu_a <= '0;
      bus.alu_b <= '0;
      bus.alu_op <= '0;
      bus.out_valid <= 1'b0;
      bus.out_result <= '0;
      bus.out_op <= '0;
      bus.out_zero <= 1'b0;
      bus.out_neg <= 1'b0;
      bus.ops_done <= '0;
    end else begin
      if (accept) begin
        bus.alu_a <= a_nx;
        bus.alu_b <= bus.in_b;
        bus.alu_op <= bus.in_op;
      end
      if (state == S_EXEC) begin
        bus.out_valid <= 1'b1;
        bus.out_result <= sel;
        bus.out_op <= bus.alu_op;
        bus.out_zero <= sel == '0;
        bus.out_neg <= sel[DATA_W-1];
      end else if (handoff) bus.out_valid <= 1'b0;
      if (handoff) bus.ops_done <= bus.ops_done + 1'b1;
    end
endmodule

// File: tb/tb_alu_result_collector.sv
// tb_alu_result_collector: table vectors, hand sequences and randomized ops against a behavioural model
module tb_alu_result_collector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_checks = 0;
  int n_fail = 0;
  logic [7:0] cnt = '0;
  logic [3:0] last = '0;
`ifdef ALU_COLLECTOR_ACC_MODE_EN
  localparam bit ACC_ON = 1'b1;
`else
  localparam bit ACC_ON = 1'b0;
`endif
  alu_result_collector_if #(.DATA_W(4), .CNT_W(8)) bus ();
  alu_result_collector #(.DATA_W(4), .CNT_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  assign bus.alu_add = bus.alu_a + bus.alu_b;
  assign bus.alu_sub = bus.alu_a - bus.alu_b;
  assign bus.alu_not = ~bus.alu_a;
  assign bus.alu_and = bus.alu_a & bus.alu_b;
  assign bus.alu_or = bus.alu_a | bus.alu_b;
  assign bus.alu_xor = bus.alu_a ^ bus.alu_b;
  assign bus.alu_lt = $signed(bus.alu_a) < $signed(bus.alu_b);
  assign bus.alu_eq = bus.alu_a == bus.alu_b;
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] res;
    logic zero;
    logic neg;
  } vec_t;
  function automatic logic [3:0] ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return ~a;
      3'd3: return a & b;
      3'd4: return a | b;
      3'd5: return a ^ b;
      3'd6: return {3'b000, $signed(a) < $signed(b)};
      default: return {3'b000, a == b};
    endcase
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic acc,
                       input logic [3:0] res, input logic zero, input logic neg, input int stall);
    logic [3:0] ae;
    ae = (ACC_ON && acc) ? last : a;
    @(negedge clk);
    check("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_op = op;
    bus.in_acc = acc;
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("alu_a", bus.alu_a, ae);
    check("alu_b", bus.alu_b, b);
    check("alu_op", bus.alu_op, op);
    check("valid_exec", bus.out_valid, 0);
    check("ready_exec", bus.in_ready, 0);
    @(negedge clk);
    for (int i = 0; i < stall; i++) begin
      check("hold_valid", bus.out_valid, 1);
      check("hold_result", bus.out_result, res);
      check("hold_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    check("out_valid", bus.out_valid, 1);
    check("out_result", bus.out_result, res);
    check("out_zero", bus.out_zero, zero);
    check("out_neg", bus.out_neg, neg);
    check("out_op", bus.out_op, op);
    bus.out_ready = 1'b1;
    #1;
    check("ready_done", bus.in_ready, 1);
    @(negedge clk);
    bus.out_ready = 1'b0;
    cnt++;
    last = res;
    check("ops_done", bus.ops_done, cnt);
    check("valid_cleared", bus.out_valid, 0);
  endtask
  initial begin
    vec_t vt[12];
    logic [3:0] a, b, ae, r;
    logic [2:0] op;
    logic acc;
    vt[0] = '{4'd3, 4'd5, 3'd0, 4'd8, 1'b0, 1'b1};
    vt[1] = '{4'd2, 4'd3, 3'd1, 4'hF, 1'b0, 1'b1};
    vt[2] = '{4'h8, 4'd1, 3'd6, 4'd1, 1'b0, 1'b0};
    vt[3] = '{4'd5, 4'd5, 3'd7, 4'd1, 1'b0, 1'b0};
    vt[4] = '{4'd5, 4'd6, 3'd7, 4'd0, 1'b1, 1'b0};
    vt[5] = '{4'd5, 4'd0, 3'd2, 4'hA, 1'b0, 1'b1};
    vt[6] = '{4'hC, 4'hA, 3'd3, 4'h8, 1'b0, 1'b1};
    vt[7] = '{4'hC, 4'hA, 3'd4, 4'hE, 1'b0, 1'b1};
    vt[8] = '{4'hC, 4'hA, 3'd5, 4'h6, 1'b0, 1'b0};
    vt[9] = '{4'd1, 4'h8, 3'd6, 4'd0, 1'b1, 1'b0};
    vt[10] = '{4'd7, 4'd7, 3'd1, 4'd0, 1'b1, 1'b0};
    vt[11] = '{4'hF, 4'd1, 3'd0, 4'd0, 1'b1, 1'b0};
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_op = '0;
    bus.in_acc = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_ops_done", bus.ops_done, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_out_result", bus.out_result, 0);
    for (int i = 0; i < 12; i++)
      do_op(vt[i].a, vt[i].b, vt[i].op, 1'b0, vt[i].res, vt[i].zero, vt[i].neg, 0);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = 4'd3;
    bus.in_b = 4'd5;
    bus.in_op = 3'd0;
    bus.in_acc = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", bus.out_valid, 1);
      check("stall_result", bus.out_result, 8);
      check("stall_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a = 4'd2;
    bus.in_b = 4'd3;
    bus.in_op = 3'd1;
    #1;
    check("b2b_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    cnt++;
    last = 4'd8;
    check("b2b_valid_exec", bus.out_valid, 0);
    check("b2b_ops_done", bus.ops_done, cnt);
    check("b2b_alu_op", bus.alu_op, 1);
    @(negedge clk);
    check("b2b_valid", bus.out_valid, 1);
    check("b2b_result", bus.out_result, 4'hF);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    cnt++;
    last = 4'hF;
    check("b2b_ops_done2", bus.ops_done, cnt);
    do_op(4'd1, 4'd1, 3'd0, 1'b0, 4'd2, 1'b0, 1'b0, 0);
    r = ref_alu(ACC_ON ? 4'd2 : 4'd7, 4'd3, 3'd0);
    check("acc_model", r, ACC_ON ? 5 : 10);
    do_op(4'd7, 4'd3, 3'd0, 1'b1, r, r == 0, r[3], 1);
    for (int i = 0; i < 270; i++) begin
      a = 4'($urandom);
      b = 4'($urandom);
      op = 3'($urandom);
      acc = 1'($urandom);
      ae = (ACC_ON && acc) ? last : a;
      r = ref_alu(ae, b, op);
      do_op(a, b, op, acc, r, r == 0, r[3], int'($urandom_range(0, 2)));
    end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_a = 4'd4;
    bus.in_b = 4'd4;
    bus.in_op = 3'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt = '0;
    last = '0;
    #1;
    check("rexec_valid", bus.out_valid, 0);
    check("rexec_ops_done", bus.ops_done, 0);
    check("rexec_ready", bus.in_ready, 1);
    repeat (2) @(negedge clk);
    check("rexec_no_report", bus.out_valid, 0);
    do_op(4'd6, 4'd2, 3'd1, 1'b1, ACC_ON ? 4'hE : 4'd4, 1'b0, ACC_ON, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
